// File: rtl/bram_access_ctrl_pkg.sv
// Shared encodings for the BRAM access controller: FSM states and grant types.
package bram_ctrl_pkg;
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WR     = 3'd1;
    localparam logic [2:0] RD     = 3'd2;
    localparam logic [2:0] RD_CAP = 3'd3;
    localparam logic [2:0] CLEAR  = 3'd4;

    localparam logic GRANT_WR = 1'b0;
    localparam logic GRANT_RD = 1'b1;
endpackage

// File: rtl/bram_access_ctrl_if.sv
// Request, response and BRAM-side signals of the access controller.
interface bram_access_ctrl_if #(
    parameter int DW = 32,
    parameter int AW = 6
);
    logic          wr_valid, wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_valid, rd_ready;
    logic [AW-1:0] rd_addr;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          mem_write_en, mem_read_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data_in, mem_data_out;

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, rsp_ready, mem_data_out,
        output wr_ready, rd_ready, rsp_valid, rsp_data,
               mem_write_en, mem_read_en, mem_addr, mem_data_in
    );
    modport master (
        output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, rsp_ready, mem_data_out,
        input  wr_ready, rd_ready, rsp_valid, rsp_data,
               mem_write_en, mem_read_en, mem_addr, mem_data_in
    );
endinterface

// File: rtl/bram_access_ctrl_rr_arb2.sv
// Two-requester write/read arbiter; last_grant only flips on contested cycles.
module rr_arb2
    import bram_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic req_wr_i,
    input  logic req_rd_i,
    output logic gnt_wr_o,
    output logic gnt_rd_o
);
    logic last_q, last_d;

    always_comb begin
        gnt_wr_o = en_i && req_wr_i && (!req_rd_i || last_q == GRANT_RD);
        gnt_rd_o = en_i && req_rd_i && (!req_wr_i || last_q == GRANT_WR);
        last_d   = last_q;
        if (en_i && req_wr_i && req_rd_i)
            last_d = gnt_wr_o ? GRANT_WR : GRANT_RD;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_q <= GRANT_RD;
        else     last_q <= last_d;
    end
endmodule

// File: rtl/bram_access_ctrl.sv
// Serialises write/read requests onto a single-port BRAM, buffers one read
// response and runs a zero-fill sweep on init_start.
module bram_access_ctrl
    import bram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 6
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                init_start,
    output logic                init_busy,
    bram_access_ctrl_if.slave   bus
);
    logic [2:0]               state_q, state_d;
    logic                     we_q, we_d, re_q, re_d, busy_q, busy_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    din_q, din_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]    rsp_data_q, rsp_data_d;
    logic                     arb_en, rsp_free, gnt_wr, gnt_rd;

    // Readies are combinational; clr is folded in so they drop with the reset.
    assign arb_en   = (state_q == IDLE) && !init_start && !clr;
    assign rsp_free = !rsp_valid_q || bus.rsp_ready;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (clr),
        .en_i     (arb_en),
        .req_wr_i (bus.wr_valid),
        .req_rd_i (bus.rd_valid && rsp_free),
        .gnt_wr_o (gnt_wr),
        .gnt_rd_o (gnt_rd)
    );

    always_comb begin
        state_d     = state_q;
        we_d        = 1'b0;
        re_d        = 1'b0;
        busy_d      = 1'b0;
        addr_d      = '0;
        din_d       = '0;
        rsp_valid_d = rsp_valid_q && !bus.rsp_ready;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (init_start) begin
                    state_d = CLEAR;
                    we_d    = 1'b1;
                    busy_d  = 1'b1;
                end else if (gnt_wr) begin
                    state_d = WR;
                    we_d    = 1'b1;
                    addr_d  = bus.wr_addr;
                    din_d   = bus.wr_data;
                end else if (gnt_rd) begin
                    state_d = RD;
                    re_d    = 1'b1;
                    addr_d  = bus.rd_addr;
                end
            end
            WR:     state_d = IDLE;
            RD:     state_d = RD_CAP;
            RD_CAP: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                rsp_data_d  = bus.mem_data_out;
            end
            CLEAR: begin
                // Sweep ends on the last address; it never wraps back to 0.
                if (addr_q == {ADDRESS_WIDTH{1'b1}}) begin
                    state_d = IDLE;
                end else begin
                    we_d   = 1'b1;
                    busy_d = 1'b1;
                    addr_d = addr_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            busy_q      <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            re_q        <= re_d;
            busy_q      <= busy_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign init_busy        = busy_q;
    assign bus.wr_ready     = gnt_wr;
    assign bus.rd_ready     = gnt_rd;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.mem_write_en = we_q;
    assign bus.mem_read_en  = re_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_data_in  = din_q;
endmodule

// File: tb/tb_bram_access_ctrl.sv
// Directed bench for bram_access_ctrl with a BRAM model and a response scoreboard.
module tb_bram_access_ctrl;
    logic clk, clr, init_start, init_busy;
    int   total = 0, bad = 0;
    logic [31:0] ref_mem [64];
    logic [31:0] exp_q [$];
    logic [31:0] bmem [64];
    logic        written [64];

    bram_access_ctrl_if #(.DW(32), .AW(6)) bus ();

    bram_access_ctrl #(.DATA_WIDTH(32), .ADDRESS_WIDTH(6)) dut (
        .clk        (clk),
        .clr        (clr),
        .init_start (init_start),
        .init_busy  (init_busy),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input logic [5:0] a);
        return 32'hDEAD_0000 | {26'd0, a};
    endfunction

    // Single-port BRAM: registered read, write on the edge.
    always @(posedge clk) begin
        if (bus.mem_write_en) begin
            bmem[bus.mem_addr]    <= bus.mem_data_in;
            written[bus.mem_addr] <= 1'b1;
        end
        if (bus.mem_read_en)
            bus.mem_data_out <= (written[bus.mem_addr] === 1'b1) ? bmem[bus.mem_addr]
                                                                 : init_val(bus.mem_addr);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input bit ok);
        total++;
        if (!ok) begin
            bad++;
            $error("FAIL %s", tag);
        end
    endtask

    // Pops the scoreboard on every response handshake, then advances one cycle.
    task automatic tick();
        logic [31:0] e;
        @(negedge clk);
        if (!clr && bus.rsp_valid && bus.rsp_ready) begin
            chk("sb_has_entry", exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rsp_data", bus.rsp_data === e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_wr(input logic [5:0] a, input logic [31:0] d, output int n);
        n = 0;
        bus.wr_valid = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        #1;
        while (!bus.wr_ready && n < 20) begin tick(); n++; end
        chk("wr_accept_in_time", n < 20);
        ref_mem[a] = d;
        tick();
        bus.wr_valid = 1'b0;
    endtask

    task automatic do_rd(input logic [5:0] a);
        int n = 0;
        bus.rd_valid = 1'b1; bus.rd_addr = a;
        #1;
        while (!bus.rd_ready && n < 20) begin tick(); n++; end
        chk("rd_accept_in_time", n < 20);
        exp_q.push_back(ref_mem[a]);
        tick();
        bus.rd_valid = 1'b0;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_val(6'(i));
        clr = 1'b1; init_start = 1'b0;
        bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_valid = 1'b0; bus.rd_addr = '0; bus.rsp_ready = 1'b1;
        tick(); tick();
        chk("reset_outputs", {init_busy, bus.mem_write_en, bus.mem_read_en, bus.mem_addr,
                              bus.mem_data_in, bus.rsp_valid, bus.wr_ready, bus.rd_ready} === '0);
        clr = 1'b0;
        tick();

        init_start = 1'b1; tick(); init_start = 1'b0;
        repeat (17) tick();
        chk("sweep_addr17", {init_busy, bus.mem_write_en, bus.mem_addr} === {1'b1, 1'b1, 6'd17});
        clr = 1'b1; #1;
        chk("clr_outputs_zero", {init_busy, bus.mem_write_en, bus.mem_read_en, bus.mem_addr,
                                 bus.mem_data_in, bus.rsp_valid, bus.wr_ready, bus.rd_ready} === '0);
        for (int i = 0; i < 17; i++) ref_mem[i] = 32'd0;
        tick();
        clr = 1'b0;
        do_wr(6'd30, 32'h30, n);
        chk("idle_after_clr", n == 0);
        chk("no_resume_busy", init_busy === 1'b0);

        do_wr(6'd20, 32'd10, n);
        do_rd(6'd20);
        chk("rd_lat_c0", bus.rsp_valid === 1'b0);
        tick();
        chk("rd_lat_c1", bus.rsp_valid === 1'b0);
        tick();
        chk("rd_lat_c2", {bus.rsp_valid, bus.rsp_data} === {1'b1, 32'd10});
        repeat (3) tick();

        clr = 1'b1; tick(); clr = 1'b0;
        bus.wr_valid = 1'b1; bus.wr_addr = 6'd5; bus.wr_data = 32'hA5A5A5A5;
        bus.rd_valid = 1'b1; bus.rd_addr = 6'd5;
        #1;
        chk("arb1_grants", {bus.wr_ready, bus.rd_ready} === 2'b10);
        ref_mem[5] = 32'hA5A5A5A5;
        tick(); bus.wr_valid = 1'b0; #1;
        chk("arb1_rd_wait", bus.rd_ready === 1'b0);
        tick();
        chk("arb1_rd_grant", bus.rd_ready === 1'b1);
        exp_q.push_back(ref_mem[5]);
        tick(); bus.rd_valid = 1'b0;
        repeat (4) tick();
        bus.wr_valid = 1'b1; bus.wr_addr = 6'd6; bus.wr_data = 32'h600D0006;
        bus.rd_valid = 1'b1; bus.rd_addr = 6'd7;
        #1;
        chk("arb2_grants", {bus.wr_ready, bus.rd_ready} === 2'b01);
        exp_q.push_back(ref_mem[7]);
        tick(); bus.rd_valid = 1'b0; #1;
        chk("arb2_wr_wait_rd", bus.wr_ready === 1'b0);
        tick();
        chk("arb2_wr_wait_cap", bus.wr_ready === 1'b0);
        tick();
        chk("arb2_wr_grant", bus.wr_ready === 1'b1);
        ref_mem[6] = 32'h600D0006;
        tick(); bus.wr_valid = 1'b0;
        do_rd(6'd6);
        repeat (4) tick();

        bus.rsp_ready = 1'b0;
        do_rd(6'd20);
        tick(); tick();
        bus.rd_valid = 1'b1; bus.rd_addr = 6'd5; #1;
        for (int i = 0; i < 10; i++) begin
            chk("rsp_hold", {bus.rsp_valid, bus.rsp_data, bus.rd_ready} === {1'b1, 32'd10, 1'b0});
            tick();
        end
        bus.rsp_ready = 1'b1; #1;
        chk("rd_ready_on_take", bus.rd_ready === 1'b1);
        exp_q.push_back(ref_mem[5]);
        tick(); bus.rd_valid = 1'b0;
        repeat (4) tick();

        do_wr(6'd63, 32'd7, n);
        do_rd(6'd63);
        repeat (4) tick();
        init_start = 1'b1;
        bus.wr_valid = 1'b1; bus.wr_addr = 6'd1; bus.wr_data = 32'h1;
        bus.rd_valid = 1'b1; bus.rd_addr = 6'd2;
        #1;
        chk("init_wins", {bus.wr_ready, bus.rd_ready} === 2'b00);
        tick(); init_start = 1'b0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'd0;
        for (int i = 0; i < 64; i++) begin
            chk("sweep_cycle", {init_busy, bus.mem_write_en, bus.mem_read_en, bus.mem_addr,
                                bus.mem_data_in, bus.wr_ready, bus.rd_ready} ===
                               {1'b1, 1'b1, 1'b0, 6'(i), 32'd0, 2'b00});
            tick();
        end
        bus.wr_valid = 1'b0; bus.rd_valid = 1'b0; #1;
        chk("sweep_done", {init_busy, bus.mem_write_en, bus.mem_addr} === '0);
        do_rd(6'd63);
        do_rd(6'd20);
        repeat (4) tick();

        do_wr(6'd40, 32'h40, n);
        init_start = 1'b1;
        tick(); init_start = 1'b0;
        chk("init_ignored_wr", {init_busy, bus.mem_write_en} === 2'b00);
        tick();
        chk("init_ignored_later", init_busy === 1'b0);
        do_rd(6'd40);
        repeat (6) tick();

        chk("sb_drained", exp_q.size() == 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
